// File: rtl/vc_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package vc_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Every quotient bit takes this value on a divide by zero.
    localparam bit DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/vc_div_step.sv
// One restoring division iteration: shift the remainder/quotient pair left,
// trial-subtract the divisor, keep the difference if it is non-negative.
module vc_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem, quot[W-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[W]) begin
            rem_next  = trial[W-1:0];
            quot_next = {quot[W-2:0], 1'b1};
        end else begin
            rem_next  = shifted[W-1:0];
            quot_next = {quot[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/vc_iter_divider.sv
// Iterative W-bit divider with valid/ready handshakes, W+1 cycle latency.
// Signed mode is built only when VC_ITER_DIVIDER_SIGNED_EN is defined.
module vc_iter_divider
    import vc_div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_val,
    output logic         in_rdy,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_signed,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [W-1:0] out_quot,
    output logic [W-1:0] out_rem
);

    localparam int CW = $clog2(W + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  quot_r;
    logic [W-1:0]  div_r;
    logic [W-1:0]  a_r;
    logic          dbz_r;

    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  quot_step;
    logic [W-1:0]  fix_quot;
    logic [W-1:0]  fix_rem;

`ifdef VC_ITER_DIVIDER_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;
    logic sign_a;
    logic sign_b;

    always_comb begin
        sign_a = in_signed & in_a[W-1];
        sign_b = in_signed & in_b[W-1];
        a_mag  = sign_a ? (~in_a + 1'b1) : in_a;
        b_mag  = sign_b ? (~in_b + 1'b1) : in_b;
    end
`else
    logic unused_signed;
    assign unused_signed = in_signed;
    assign a_mag         = in_a;
    assign b_mag         = in_b;
`endif

    vc_div_step #(.W(W)) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (div_r),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    // Divide by zero reports the raw dividend as remainder; -2^(W-1)/-1 falls out naturally.
    always_comb begin
        fix_quot = quot_r;
        fix_rem  = rem_r;
        if (dbz_r) begin
            fix_quot = {W{DBZ_QUOT_FILL}};
            fix_rem  = a_r;
        end
`ifdef VC_ITER_DIVIDER_SIGNED_EN
        else begin
            if (neg_q_r) fix_quot = ~quot_r + 1'b1;
            if (neg_r_r) fix_rem  = ~rem_r + 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the datapath registers are plain flops, not memory, so they are all cleared on reset.
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_r    <= '0;
            quot_r   <= '0;
            div_r    <= '0;
            a_r      <= '0;
            dbz_r    <= 1'b0;
`ifdef VC_ITER_DIVIDER_SIGNED_EN
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
`endif
            in_rdy   <= 1'b1;
            out_val  <= 1'b0;
            out_quot <= '0;
            out_rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_val) begin
                        rem_r   <= '0;
                        quot_r  <= a_mag;
                        div_r   <= b_mag;
                        a_r     <= in_a;
                        dbz_r   <= (in_b == '0);
`ifdef VC_ITER_DIVIDER_SIGNED_EN
                        neg_q_r <= sign_a ^ sign_b;
                        neg_r_r <= sign_a;
`endif
                        cnt     <= CW'(W);
                        in_rdy  <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        rem_r  <= rem_step;
                        quot_r <= quot_step;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        out_quot <= fix_quot;
                        out_rem  <= fix_rem;
                        out_val  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val  <= 1'b0;
                        out_quot <= '0;
                        out_rem  <= '0;
                        in_rdy   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    in_rdy  <= 1'b1;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_iter_divider.sv
// Randomized self-checking bench for vc_iter_divider at W=8 with a behavioural model.
module tb_vc_iter_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_val = 1'b0;
    logic         in_rdy;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_signed = 1'b0;
    logic         out_val;
    logic         out_rdy = 1'b0;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;

    int n_vec = 0;
    int n_err = 0;

    vc_iter_divider #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_quot  (out_quot),
        .out_rem   (out_rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the divider's special cases.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] q, output logic [7:0] r);
        bit use_signed;
        int sa;
        int sb;
        use_signed = s;
`ifndef VC_ITER_DIVIDER_SIGNED_EN
        use_signed = 1'b0;
`endif
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
        end else if (use_signed) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q = a;
                r = 8'h00;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input int hold, input logic [7:0] eq,
                         input logic [7:0] er, input bit release_rst);
        int lat;
        @(negedge clk);
        if (release_rst) reset_n = 1'b1;
        for (int i = 0; i < 30 && !in_rdy; i++) @(negedge clk);
        check({tag, "_in_rdy_idle"}, 32'(in_rdy), 32'd1);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_val    = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs while busy; they must not disturb the operation.
        in_val    = 1'($urandom);
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_signed = 1'($urandom);
        check({tag, "_in_rdy_busy"}, 32'(in_rdy), 32'd0);
        check({tag, "_quot_zero_busy"}, 32'(out_quot), 32'd0);
        lat = 0;
        while (!out_val && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_val = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_quot"}, 32'(out_quot), 32'(eq));
        check({tag, "_rem"}, 32'(out_rem), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_val"}, 32'(out_val), 32'd1);
            check({tag, "_hold_in_rdy"}, 32'(in_rdy), 32'd0);
            check({tag, "_hold_q_r"}, {16'd0, out_quot, out_rem}, {16'd0, eq, er});
        end
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check({tag, "_retire_val"}, 32'(out_val), 32'd0);
        check({tag, "_retire_in_rdy"}, 32'(in_rdy), 32'd1);
        check({tag, "_retire_zero"}, {16'd0, out_quot, out_rem}, 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [7:0] eq;
        logic [7:0] er;
        bit         saw_val;

        #12;
        check("reset_in_rdy", 32'(in_rdy), 32'd1);
        check("reset_out_val", 32'(out_val), 32'd0);
        check("reset_outputs", {16'd0, out_quot, out_rem}, 32'd0);

        do_op("u100_7", 8'd100, 8'd7, 1'b0, 0, 8'd14, 8'd2, 1'b1);
        do_op("u37_0", 8'd37, 8'd0, 1'b0, 0, 8'hFF, 8'h25, 1'b0);
        do_op("s37_0", 8'd37, 8'd0, 1'b1, 0, 8'hFF, 8'h25, 1'b0);
`ifdef VC_ITER_DIVIDER_SIGNED_EN
        do_op("s_m7_2", 8'hF9, 8'h02, 1'b1, 0, 8'hFD, 8'hFF, 1'b0);
        do_op("s_ovf", 8'h80, 8'hFF, 1'b1, 0, 8'h80, 8'h00, 1'b0);
`else
        do_op("s_m7_2_unsigned", 8'hF9, 8'h02, 1'b1, 0, 8'd124, 8'd1, 1'b0);
        do_op("s_ovf_unsigned", 8'h80, 8'hFF, 1'b1, 0, 8'h00, 8'h80, 1'b0);
`endif
        do_op("backpressure", 8'd200, 8'd9, 1'b0, 5, 8'd22, 8'd2, 1'b0);

        // Reset three cycles into CALC must abort the operation.
        @(negedge clk);
        in_a   = 8'd250;
        in_b   = 8'd3;
        in_val = 1'b1;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_in_rdy", 32'(in_rdy), 32'd1);
        check("abort_out_val", 32'(out_val), 32'd0);
        check("abort_outputs", {16'd0, out_quot, out_rem}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_val = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_val) saw_val = 1'b1;
        end
        check("abort_no_result", 32'(saw_val), 32'd0);
        do_op("u9_3", 8'd9, 8'd3, 1'b0, 0, 8'd3, 8'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'h80;
                rb = 8'hFF;
            end
            model(ra, rb, rs, eq, er);
            do_op($sformatf("rnd%0d", n), ra, rb, rs, int'($urandom_range(0, 3)), eq, er, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
